// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_op_1,
  input  logic [DATA_W-1:0] req0_op_2,
  input  logic [3:0]        req0_alu_ctrl,
  input  logic [DATA_W-1:0] req1_op_1,
  input  logic [DATA_W-1:0] req1_op_2,
  input  logic [3:0]        req1_alu_ctrl,
  output logic [DATA_W-1:0] alu_op_1,
  output logic [DATA_W-1:0] alu_op_2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                rsp_id_q, rsp_id_d;
  logic                gnt;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    ctrl_d       = ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_id_d     = rsp_id_q;
    req_ready    = 2'b00;
    gnt          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          // Under contention the requester that did not win last time goes first.
          gnt          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
          req_ready    = gnt ? 2'b10 : 2'b01;
          op1_d        = gnt ? req1_op_1     : req0_op_1;
          op2_d        = gnt ? req1_op_2     : req0_op_2;
          ctrl_d       = gnt ? req1_alu_ctrl : req0_alu_ctrl;
          owner_d      = gnt;
          last_grant_d = gnt;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_result_d = alu_result;
        rsp_ovf_d    = alu_ovf;
        rsp_id_d     = owner_q;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      ctrl_q       <= ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_op_1   = op1_q;
  assign alu_op_2   = op2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a cycle-count reference model predicts grants and response timing,
// and a separate monitor checks every presented response against a queue of expected results.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_op_1, req0_op_2, req1_op_1, req1_op_2;
  logic [3:0]  req0_alu_ctrl, req1_alu_ctrl;
  logic [31:0] alu_op_1, alu_op_2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [31:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_op_1     (req0_op_1),
    .req0_op_2     (req0_op_2),
    .req0_alu_ctrl (req0_alu_ctrl),
    .req1_op_1     (req1_op_1),
    .req1_op_2     (req1_op_2),
    .req1_alu_ctrl (req1_alu_ctrl),
    .alu_op_1      (alu_op_1),
    .alu_op_2      (alu_op_2),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_ovf       (alu_ovf),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_ovf       (rsp_ovf)
  );

  // Shared ALU: AND, OR, ADD (carry), SUB (borrow), SLT; anything else yields zero.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a} + {1'b0, b};
      4'b0110: return {1'b0, a} - {1'b0, b};
      4'b0111: return {32'd0, ($signed(a) < $signed(b))};
      default: return 33'd0;
    endcase
  endfunction

  assign {alu_ovf, alu_result} = alu_fn(alu_op_1, alu_op_2, alu_ctrl);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic        ovf;
    logic [31:0] result;
  } rsp_t;

  rsp_t sb[$];

  // Reference model in terms of cycle numbers: grant at c, response visible from c+2,
  // next grant no earlier than the cycle after the response is taken.
  int   cyc        = 0;
  int   next_free  = 0;
  int   resp_start = 0;
  bit   awaiting   = 0;
  logic m_last     = 1'b1;

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       exp_valid;
    logic       g;
    rsp_t       e;
    cyc++;
    if (rst) begin
      sb.delete();
      awaiting  = 0;
      m_last    = 1'b1;
      next_free = 0;
      check("rsp_valid_in_reset", {63'd0, rsp_valid}, 64'd0);
    end else begin
      exp_valid = awaiting && (cyc >= resp_start);
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
      exp_ready = 2'b00;
      if (!awaiting && cyc >= next_free && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? !m_last : (req_valid == 2'b10);
        exp_ready = g ? 2'b10 : 2'b01;
        e.id = g;
        {e.ovf, e.result} = g ? alu_fn(req1_op_1, req1_op_2, req1_alu_ctrl)
                              : alu_fn(req0_op_1, req0_op_2, req0_alu_ctrl);
        sb.push_back(e);
        m_last     = g;
        awaiting   = 1;
        resp_start = cyc + 2;
      end else if (exp_valid && rsp_ready) begin
        awaiting  = 0;
        next_free = cyc + 1;
      end
      check("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
    end
  end

  // Monitor: whenever a response is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      check("rsp_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        check("rsp_id", {63'd0, rsp_id}, {63'd0, sb[0].id});
        check("rsp_result", {32'd0, rsp_result}, {32'd0, sb[0].result});
        check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, sb[0].ovf});
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    if (r == 0) begin
      req0_op_1 = a; req0_op_2 = b; req0_alu_ctrl = c;
    end else begin
      req1_op_1 = a; req1_op_2 = b; req1_alu_ctrl = c;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    set_req(0, 32'd0, 32'd0, 4'd0);
    set_req(1, 32'd0, 32'd0, 4'd0);
    cycle();
    @(negedge clk);
    check("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
    check("reset_alu_op_1", {32'd0, alu_op_1}, 64'd0);
    check("reset_req_ready", {62'd0, req_ready}, 64'd0);
    cycle();
    rst = 1'b0;

    // Single request 5+7.
    rsp_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, 4'b0010);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();
    @(negedge clk);
    check("single_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_result", {32'd0, rsp_result}, 64'd12);
    check("single_id", {63'd0, rsp_id}, 64'd0);
    cycle();

    // Overflow on add.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();
    @(negedge clk);
    check("ovf_result", {32'd0, rsp_result}, 64'd0);
    check("ovf_flag", {63'd0, rsp_ovf}, 64'd1);
    cycle();

    // Operand change right after the handshake must not leak into the result.
    set_req(1, 32'd10, 32'd3, 4'b0110);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    set_req(1, 32'd100, 32'd50, 4'b0010);
    cycle();
    @(negedge clk);
    check("opchg_result", {32'd0, rsp_result}, 64'd7);
    check("opchg_id", {63'd0, rsp_id}, 64'd1);
    cycle();

    // Sustained contention with backpressure bursts.
    set_req(0, 32'd1, 32'd2, 4'b0001);
    set_req(1, 32'd8, 32'd9, 4'b0000);
    req_valid = 2'b11;
    for (int i = 0; i < 24; i++) begin
      rsp_ready = (i % 8) >= 5;
      cycle();
    end

    // Reset during EXEC: grant requester 0 alone, then abort.
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    repeat (4) cycle();
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    rst = 1'b1;
    cycle();
    @(negedge clk);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_rsp_result", {32'd0, rsp_result}, 64'd0);
    check("abort_alu_op_2", {32'd0, alu_op_2}, 64'd0);
    cycle();
    rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check("post_reset_grant", {62'd0, req_ready}, 64'd1);
    cycle();
    req_valid = 2'b00;
    repeat (3) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      set_req(0, rand_op(), rand_op(), 4'($urandom));
      set_req(1, rand_op(), rand_op(), 4'($urandom));
      cycle();
    end

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) cycle();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
